// File: rtl/qkd_sift_if.sv
// Handshake and data bundle between the sifting stage and its neighbours.
// The master side drives the beats and key_ready; the slave is qkd_sift_packer.
interface qkd_sift_if #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned SC_W = $clog2(KEY_BITS + 1);

  logic                  start;
  logic                  abort;
  logic                  in_valid;
  logic                  in_ready;
  logic [2*LANES-1:0]    qubit;
  logic [LANES-1:0]      r_bases;
  logic [LANES-1:0]      s_bases;
  logic [KEY_BITS-1:0]   key_out;
  logic                  key_valid;
  logic                  key_ready;
  logic [SC_W-1:0]       sifted_count;
  logic [CNT_W-1:0]      total_count;
  logic [CNT_W-1:0]      err_count;

  modport master (
    output start, abort, in_valid, qubit, r_bases, s_bases, key_ready,
    input  in_ready, key_out, key_valid, sifted_count, total_count, err_count
  );

  modport slave (
    input  start, abort, in_valid, qubit, r_bases, s_bases, key_ready,
    output in_ready, key_out, key_valid, sifted_count, total_count, err_count
  );
endinterface

// File: rtl/qkd_sift_packer.sv
// BB84 sifting stage: drops basis-mismatched lanes, compacts the surviving bits
// into a KEY_BITS key and hands it off over a valid/ready handshake.
module qkd_sift_packer #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  qkd_sift_if.slave  bus
);
  localparam int unsigned SC_W  = $clog2(KEY_BITS + 1);
  localparam int unsigned POS_W = $clog2(KEY_BITS + LANES + 1);
  localparam int unsigned IDX_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam int unsigned LC_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state, state_nxt;
  logic [KEY_BITS-1:0] key_q, key_nxt, key_acc;
  logic [SC_W-1:0]     sc_q, sc_nxt;
  logic [CNT_W-1:0]    tot_q, tot_nxt, err_q, err_nxt;
  logic                in_ready_q, key_valid_q;
  logic [LANES-1:0]    keep, err_lane;
  logic [POS_W-1:0]    pos, sc_clamp;
  logic [LC_W-1:0]     n_err;
  logic [SUM_W-1:0]    tot_sum, err_sum;

  // Per-lane classification of the presented beat
  always_comb begin
    keep     = '0;
    err_lane = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      keep[i]     = (bus.r_bases[i] == bus.s_bases[i]) && (bus.qubit[2*i+1] == bus.r_bases[i]);
      err_lane[i] = (bus.r_bases[i] == bus.s_bases[i]) && !keep[i];
    end
  end

  // Compact kept bits above the current fill level; bits past KEY_BITS fall off
  always_comb begin
    key_acc = key_q;
    pos     = POS_W'(sc_q);
    n_err   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (keep[i]) begin
        if (pos < POS_W'(KEY_BITS)) key_acc[IDX_W'(pos)] = bus.qubit[2*i];
        pos = pos + POS_W'(1);
      end
      if (err_lane[i]) n_err = n_err + LC_W'(1);
    end
    sc_clamp = (pos > POS_W'(KEY_BITS)) ? POS_W'(KEY_BITS) : pos;
    tot_sum  = {1'b0, tot_q} + SUM_W'(LANES);
    err_sum  = {1'b0, err_q} + SUM_W'(n_err);
  end

  // Next-state and register update logic
  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    sc_nxt    = sc_q;
    tot_nxt   = tot_q;
    err_nxt   = err_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_COLLECT;
          key_nxt   = '0;
          sc_nxt    = '0;
          tot_nxt   = '0;
          err_nxt   = '0;
        end
      end
      S_COLLECT: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
          key_nxt   = '0;
          sc_nxt    = '0;
        end else if (bus.in_valid) begin
          key_nxt = key_acc;
          sc_nxt  = SC_W'(sc_clamp);
          tot_nxt = tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];
          err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          if (sc_clamp == POS_W'(KEY_BITS)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
          key_nxt   = '0;
          sc_nxt    = '0;
        end else if (bus.key_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      key_q       <= '0;
      sc_q        <= '0;
      tot_q       <= '0;
      err_q       <= '0;
      in_ready_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_q       <= key_nxt;
      sc_q        <= sc_nxt;
      tot_q       <= tot_nxt;
      err_q       <= err_nxt;
      in_ready_q  <= (state_nxt == S_COLLECT);
      key_valid_q <= (state_nxt == S_DONE);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.key_valid    = key_valid_q;
  assign bus.key_out      = key_q;
  assign bus.sifted_count = sc_q;
  assign bus.total_count  = tot_q;
  assign bus.err_count    = err_q;
endmodule

// File: tb/tb_qkd_sift_packer.sv
// Bench for qkd_sift_packer: directed vector table, async-reset sequence and
// random traffic checked every cycle against a bit-queue model of sifting.
module tb_qkd_sift_packer;
  localparam int unsigned LANES = 8;
  localparam int unsigned KB    = 16;
  localparam int unsigned CW    = 6;
  localparam int unsigned IDXW  = $clog2(KB);
  localparam int          CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qkd_sift_if #(.LANES(LANES), .KEY_BITS(KB), .CNT_W(CW)) bus ();

  qkd_sift_packer #(.LANES(LANES), .KEY_BITS(KB), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 key held
  int            m_phase, m_sc, m_tot, m_err;
  logic [KB-1:0] m_key;

  typedef struct {
    logic        st, ab, iv;
    logic [15:0] q;
    logic [7:0]  r, s;
    logic        kr;
    logic [15:0] key;
    int          sc, tot, err;
    logic        vld, rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, ab, iv, input logic [15:0] q,
                              input logic [7:0] r, s, input logic kr,
                              input logic [15:0] key, input int sc, tot, err,
                              input logic vld, rdy);
    vec_t v;
    v.st = st; v.ab = ab; v.iv = iv; v.q = q; v.r = r; v.s = s; v.kr = kr;
    v.key = key; v.sc = sc; v.tot = tot; v.err = err; v.vld = vld; v.rdy = rdy;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sc = 0; m_tot = 0; m_err = 0; m_key = '0;
  endtask

  task automatic model_edge(input logic st, ab, iv, input logic [15:0] q,
                            input logic [7:0] r, s, input logic kr);
    bit kept[$];
    int nerr;
    kept = {};
    nerr = 0;
    case (m_phase)
      0: if (st) begin
        m_key = '0; m_sc = 0; m_tot = 0; m_err = 0; m_phase = 1;
      end
      1: if (ab) begin
        m_key = '0; m_sc = 0; m_phase = 0;
      end else if (iv) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (r[i] == s[i]) begin
            if (q[2*i+1] == r[i]) kept.push_back(q[2*i]);
            else nerr++;
          end
        end
        foreach (kept[k]) begin
          if (m_sc < int'(KB)) begin
            m_key[IDXW'(m_sc)] = kept[k];
            m_sc++;
          end
        end
        m_tot = sat(m_tot + int'(LANES));
        m_err = sat(m_err + nerr);
        if (m_sc == int'(KB)) m_phase = 2;
      end
      2: if (ab) begin
        m_key = '0; m_sc = 0; m_phase = 0;
      end else if (kr) begin
        m_phase = 0;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_model();
    chk("mdl_key",   64'(bus.key_out),      64'(m_key));
    chk("mdl_sc",    64'(bus.sifted_count), 64'(m_sc));
    chk("mdl_tot",   64'(bus.total_count),  64'(m_tot));
    chk("mdl_err",   64'(bus.err_count),    64'(m_err));
    chk("mdl_valid", 64'(bus.key_valid),    64'(m_phase == 2));
    chk("mdl_ready", 64'(bus.in_ready),     64'(m_phase == 1));
  endtask

  task automatic drive(input logic st, ab, iv, input logic [15:0] q,
                       input logic [7:0] r, s, input logic kr);
    bus.start = st; bus.abort = ab; bus.in_valid = iv; bus.qubit = q;
    bus.r_bases = r; bus.s_bases = s; bus.key_ready = kr;
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later
  task automatic step(input logic st, ab, iv, input logic [15:0] q,
                      input logic [7:0] r, s, input logic kr);
    @(negedge clk);
    drive(st, ab, iv, q, r, s, kr);
    @(posedge clk);
    model_edge(st, ab, iv, q, r, s, kr);
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key"},   64'(bus.key_out),      64'(0));
    chk({tag, "_valid"}, 64'(bus.key_valid),    64'(0));
    chk({tag, "_ready"}, 64'(bus.in_ready),     64'(0));
    chk({tag, "_sc"},    64'(bus.sifted_count), 64'(0));
    chk({tag, "_tot"},   64'(bus.total_count),  64'(0));
    chk({tag, "_err"},   64'(bus.err_count),    64'(0));
  endtask

  initial begin
    logic [7:0] r, s;
    drive(0, 0, 0, 16'h0, 8'h0, 8'h0, 0);
    model_reset();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(1,0,0, 16'h0000, 8'h00, 8'h00, 0, 16'h0000,  0,  0, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'h44BB, 8'h0F, 8'h0F, 0, 16'h00A5,  8,  8, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'h1234, 8'h0F, 8'hF0, 0, 16'h00A5,  8, 16, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'hAAAA, 8'h00, 8'h00, 0, 16'h00A5,  8, 24, 8, 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,0,0, 16'hFFFF, 8'hFF, 8'hFF, 0, 16'h00A5, 8, 24, 8, 0, 1));
    tbl.push_back(mk(1,0,0, 16'h0000, 8'h00, 8'h00, 0, 16'h00A5,  8, 24, 8, 0, 1));
    tbl.push_back(mk(0,0,1, 16'h00FF, 8'hFF, 8'h0F, 0, 16'h0FA5, 12, 32, 8, 0, 1));
    tbl.push_back(mk(0,0,1, 16'h5511, 8'h00, 8'h00, 0, 16'h5FA5, 16, 40, 8, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,1, 16'hFFFF, 8'hFF, 8'hFF, 0, 16'h5FA5, 16, 40, 8, 1, 0));
    tbl.push_back(mk(0,0,0, 16'h0000, 8'h00, 8'h00, 1, 16'h5FA5, 16, 40, 8, 0, 0));
    tbl.push_back(mk(0,0,1, 16'h44BB, 8'h0F, 8'h0F, 0, 16'h5FA5, 16, 40, 8, 0, 0));
    tbl.push_back(mk(1,1,0, 16'h0000, 8'h00, 8'h00, 0, 16'h0000,  0,  0, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'h44BB, 8'h0F, 8'h0F, 0, 16'h00A5,  8,  8, 0, 0, 1));
    tbl.push_back(mk(0,1,1, 16'hFFFF, 8'hFF, 8'hFF, 0, 16'h0000,  0,  8, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 16'h0000, 8'h00, 8'h00, 0, 16'h0000,  0,  0, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'hFFFF, 8'hFF, 8'hFF, 0, 16'h00FF,  8,  8, 0, 0, 1));
    tbl.push_back(mk(0,0,1, 16'hFFFF, 8'hFF, 8'hFF, 0, 16'hFFFF, 16, 16, 0, 1, 0));
    tbl.push_back(mk(0,1,0, 16'h0000, 8'h00, 8'h00, 1, 16'h0000,  0, 16, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 16'h0000, 8'h00, 8'h00, 0, 16'h0000,  0,  0, 0, 0, 1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,1, 16'h1234, 8'h0F, 8'hF0, 0, 16'h0000, 0, sat(8*k), 0, 0, 1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,1, 16'hAAAA, 8'h00, 8'h00, 0, 16'h0000, 0, CMAX, sat(8*k), 0, 1));
    tbl.push_back(mk(0,1,0, 16'h0000, 8'h00, 8'h00, 0, 16'h0000,  0, CMAX, CMAX, 0, 0));

    foreach (tbl[n]) begin
      step(tbl[n].st, tbl[n].ab, tbl[n].iv, tbl[n].q, tbl[n].r, tbl[n].s, tbl[n].kr);
      chk($sformatf("vec%0d_key", n),   64'(bus.key_out),      64'(tbl[n].key));
      chk($sformatf("vec%0d_sc", n),    64'(bus.sifted_count), 64'(tbl[n].sc));
      chk($sformatf("vec%0d_tot", n),   64'(bus.total_count),  64'(tbl[n].tot));
      chk($sformatf("vec%0d_err", n),   64'(bus.err_count),    64'(tbl[n].err));
      chk($sformatf("vec%0d_valid", n), 64'(bus.key_valid),    64'(tbl[n].vld));
      chk($sformatf("vec%0d_ready", n), 64'(bus.in_ready),     64'(tbl[n].rdy));
    end

    // Reset asserted between clock edges while a beat is being presented
    step(1, 0, 0, 16'h0000, 8'h00, 8'h00, 0);
    step(0, 0, 1, 16'h44BB, 8'h0F, 8'h0F, 0);
    chk("pre_rst_sc", 64'(bus.sifted_count), 64'(8));
    @(negedge clk);
    drive(0, 0, 1, 16'h44BB, 8'h0F, 8'h0F, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 8'h0, 8'h0, 0);
    model_reset();

    for (int n = 0; n < 800; n++) begin
      r = 8'($urandom);
      s = r ^ 8'($urandom & $urandom & $urandom);
      step((m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           16'($urandom), r, s,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qkd_sift_packer.md
Name: qkd_sift_packer

Overview:
- Streaming, parametrised BB84 sifting stage.
- Accepts LANES qubit/basis pairs per beat through a valid/ready handshake.
- Discards lanes whose bases differ and counts basis-inconsistent detections.
- Compacts the surviving bits in lane order into a KEY_BITS sifted-key register, then presents the key on a valid/ready output handshake to the downstream reconciliation and privacy-amplification stages.

Parameters:
- LANES, 8: qubits per input beat.
- KEY_BITS, 128: sifted key length to collect.
- CNT_W, 16: width of the saturating total and error counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a key collection.
- abort  in  1  cancels the collection in progress.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- qubit  in  2*LANES  lane i at [2i+1:2i]. Encoding: 00=0°, 01=90°, 10=45°, 11=135°.
- r_bases  in  LANES  receiver basis per lane (0 rectilinear, 1 diagonal).
- s_bases  in  LANES  sender basis per lane.
- key_out  out  KEY_BITS  sifted key, bit 0 = first sifted bit.
- key_valid  out  1  key_out complete.
- key_ready  in  1  consumer accepts the key.
- sifted_count  out  $clog2(KEY_BITS+1)  bits stored so far.
- total_count  out  CNT_W  qubits accepted, saturating.
- err_count  out  CNT_W  basis-inconsistent detections, saturating.

Behaviour:
- Reset (async, rst=1): state IDLE; key_out=0, key_valid=0, in_ready=0, sifted_count=0, total_count=0, err_count=0.
- Lane classification, per lane i, combinational on the accepted beat:
  - match = (r_bases[i]==s_bases[i]).
  - keep = match & (qubit[2i+1]==r_bases[i]).
  - bit = qubit[2i].
  - err = match & ~keep.
  - Lanes with match=0 are dropped silently.
- State machine: IDLE, COLLECT, DONE.
  - IDLE:
    - start=1 clears key_out, sifted_count, total_count and err_count, then moves to COLLECT on the next edge.
    - in_ready=0, key_valid=0.
  - COLLECT:
    - in_ready=1. A beat is accepted on an edge where in_valid & in_ready & ~abort.
    - On acceptance, kept bits are compacted in ascending lane order and written to key_out[sifted_count + k] for the k-th kept lane.
    - sifted_count += number of kept lanes, clamped at KEY_BITS. Kept bits beyond KEY_BITS are discarded.
    - total_count += LANES and err_count += number of err lanes, both saturating at 2^CNT_W-1.
    - If sifted_count reaches KEY_BITS on that edge, move to DONE. key_valid is visible the following cycle; latency is 1 cycle from the accepting edge.
    - in_valid=0 stalls; nothing changes.
  - DONE:
    - in_ready=0, key_valid=1, key_out stable.
    - key_valid & key_ready moves to IDLE on that edge; key_out, sifted_count and the counters hold their values until the next start.
- abort:
  - In COLLECT or DONE, abort moves to IDLE and clears key_out and sifted_count. The counters hold.
  - abort in the same cycle as an in_valid beat: abort wins and the beat is not counted.
  - abort together with key_ready in DONE: treated as abort.
- start is ignored outside IDLE. start and abort together in IDLE: start proceeds.
- Counters update only on accepted beats.
- in_ready depends only on state, with no combinational path from in_valid.
- Asynchronous reset mid-collection returns to the reset values immediately; the partial key is lost.

Test Plan:
- Reset: assert rst for 3 cycles -> key_out=0, key_valid=0, in_ready=0, all counts 0. Release, then pulse start -> in_ready=1 next cycle.
- Full-keep beat (LANES=8, KEY_BITS=16): r_bases=s_bases=8'h0F, qubit=16'h44BB, in_valid=1 -> key_out[7:0]=8'hA5, sifted_count=8, total_count=8, err_count=0, key_valid=0.
- Basis mismatch: r_bases=8'h0F, s_bases=8'hF0, any qubit -> sifted_count unchanged, total_count +8, err_count unchanged.
- Inconsistent detections: r_bases=s_bases=8'h00, qubit=16'hAAAA -> err_count +8, sifted_count unchanged. Then in_valid=0 for 5 cycles -> no counter change.
- Overflow and handshake: sifted_count=12, then a beat with 8 kept lanes -> only lanes 0-3 stored in key_out[15:12], sifted_count=16. Next cycle key_valid=1, in_ready=0. Hold key_ready=0 for 4 cycles -> key_out stable. Pulse key_ready -> key_valid=0, state IDLE.
- Abort and reset mid-operation: after 8 bits are stored, assert abort together with in_valid -> beat not counted, key_out=0, sifted_count=0, in_ready=0. Repeat the run and assert rst mid-beat -> outputs return to reset values asynchronously.
